// File: rtl/if_stage.sv
// Instruction fetch stage: word fetches over req/ack, in-order rvalid data into a small prefetch FIFO, one instruction per cycle to ID.
// Latency: rvalid in cycle N with an empty FIFO and no stall -> valid instruction in N+1; one transaction outstanding at a time.
// Backpressure: stall holds the output registers while returning words fill the FIFO; no request is issued while the FIFO is full.
//
// Ports (if_stage):
//   clk, rst                         clock, asynchronous active-low reset
//   stall, redirect, redirect_pc     ID hold request, control-flow change and its target
//   imem_req, imem_addr, imem_ack    fetch request handshake
//   imem_rvalid, imem_rdata          in-order read return
//   instruction, pc, pc_plus_4       registered instruction to ID and its address
//   valid                            instruction/pc hold a real fetched instruction

// Generic FIFO with synchronous flush; the caller never pushes into a full FIFO.
// Latency: the head is visible the cycle after the push; count is registered.
// Backpressure: none internally; the caller gates push_vld on count.
module fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           push_vld,
    input  logic [WIDTH-1:0]               push_dat,
    input  logic                           pop_rdy,
    output logic [WIDTH-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop   = pop_rdy && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)   rd_ptr <= ptr_inc(rd_ptr);
            if (push_vld && !do_pop)      count <= count + CW'(1);
            else if (!push_vld && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'hBFC00000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic        valid
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] fifo_cnt;
    logic [63:0]   fifo_head;
    logic          fifo_empty;
    logic          accept;
    logic          deliver;
    logic          bypass;
    logic          push_vld;
    logic          pop_rdy;
    logic [31:0]   rsp_pc;
    logic [31:0]   head_pc;
    logic [31:0]   head_word;
    logic [31:0]   target_pc;

    assign fifo_empty = (fifo_cnt == '0);

    // Request depends only on state, occupancy and reset, never on imem_ack.
    assign imem_req  = rst && (state == FETCH) && (fifo_cnt < CW'(FIFO_DEPTH));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ack;

    // Masking keeps every redirect_pc bit in the expression while forcing word alignment.
    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    // In WAIT fetch_pc has already stepped past the outstanding word, so the
    // returning word's address is one word back (wraps with fetch_pc).
    assign rsp_pc   = fetch_pc - 32'd4;

    // A word returning during a redirect is wrong-path and is dropped.
    assign deliver  = (state == WAIT) && imem_rvalid && !redirect;
    assign bypass   = deliver && !stall && fifo_empty;
    assign push_vld = deliver && !bypass;
    assign pop_rdy  = !stall && !redirect;

    assign head_pc   = fifo_head[63:32];
    assign head_word = fifo_head[31:0];

    fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push_vld (push_vld),
        .push_dat ({rsp_pc, imem_rdata}),
        .pop_rdy  (pop_rdy),
        .head_dat (fifo_head),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
        end else begin
            if (redirect)    fetch_pc <= target_pc;
            else if (accept) fetch_pc <= fetch_pc + 32'd4;

            case (state)
                FETCH: begin
                    // An ack coinciding with a redirect leaves a stale response in flight.
                    if (accept) state <= redirect ? DISCARD : WAIT;
                end
                WAIT: begin
                    if (imem_rvalid)   state <= FETCH;
                    else if (redirect) state <= DISCARD;
                end
                DISCARD: begin
                    // The stale response retires the outstanding transaction even if
                    // another redirect lands in the same cycle.
                    if (imem_rvalid) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instruction <= 32'h0;
            pc          <= 32'h0;
            pc_plus_4   <= 32'h0;
            valid       <= 1'b0;
        end else if (redirect) begin
            instruction <= 32'h0;
            valid       <= 1'b0;
        end else if (!stall) begin
            if (!fifo_empty) begin
                instruction <= head_word;
                pc          <= head_pc;
                pc_plus_4   <= head_pc + 32'd4;
                valid       <= 1'b1;
            end else if (bypass) begin
                instruction <= imem_rdata;
                pc          <= rsp_pc;
                pc_plus_4   <= rsp_pc + 32'd4;
                valid       <= 1'b1;
            end else begin
                instruction <= 32'h0;
                valid       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'hBFC00000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_ack = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        valid;

    int vectors = 0;
    int miscompares = 0;

    // Memory model state: one outstanding transaction.
    bit          pend = 1'b0;
    int          pend_lat = 0;
    logic [31:0] pend_addr = 32'h0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc          (pc),
        .pc_plus_4   (pc_plus_4),
        .valid       (valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
    endfunction

    // One cycle of the memory responder; called just after a falling edge,
    // returns just after the next falling edge.
    task automatic mem_step(input int lat, input bit rnd);
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        if (pend) begin
            if (pend_lat == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend        = 1'b0;
            end else begin
                pend_lat = pend_lat - 1;
            end
        end else if (imem_req && (!rnd || $urandom_range(0, 3) != 0)) begin
            imem_ack  = 1'b1;
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_lat  = rnd ? int'($urandom_range(0, lat)) : lat;
        end
        @(posedge clk);
        @(negedge clk);
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs the memory until the DUT is idle in FETCH with a request up.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!pend && imem_req) begin
                ok = 1'b1;
                break;
            end
            mem_step(0, 1'b0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (valid !== 1'b0 || instruction !== 32'h0 || pc !== 32'h0 || pc_plus_4 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b i=%h pc=%h pp4=%h, want 0/0/0/0", valid, instruction, pc, pc_plus_4);
        end
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_req: got %b want 0", imem_req);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL first_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_reset_fetch();
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_req_low: got %b want 0", imem_req);
        end
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h24010001;
        cyc();
        imem_rvalid = 1'b0;
        vectors++;
        if (valid !== 1'b1 || instruction !== 32'h24010001 || pc !== RESET_PC || pc_plus_4 !== 32'hBFC00004) begin
            miscompares++;
            $display("FAIL first_instr: got v=%b i=%h pc=%h pp4=%h want 1/24010001/bfc00000/bfc00004",
                     valid, instruction, pc, pc_plus_4);
        end
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hBFC00004) begin
            miscompares++;
            $display("FAIL second_req: got req=%b addr=%h want 1/bfc00004", imem_req, imem_addr);
        end
    endtask

    task automatic test_stall_fill();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_step(0, 1'b0);
            vectors++;
            if (valid !== 1'b1 || instruction !== 32'h24010001 || pc !== RESET_PC) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got v=%b i=%h pc=%h want 1/24010001/bfc00000", i, valid, instruction, pc);
            end
        end
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL full_req_low: got %b want 0", imem_req);
        end
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] ea;
            ea = 32'hBFC00004 + 32'(4 * i);
            mem_step(0, 1'b0);
            vectors++;
            if (valid !== 1'b1 || pc !== ea || instruction !== mem_word(ea)) begin
                miscompares++;
                $display("FAIL drain[%0d]: got v=%b pc=%h i=%h want 1/%h/%h", i, valid, pc, instruction, ea, mem_word(ea));
            end
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        bit seen;
        wait_req(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rw_idle_timeout: got no request, want request");
        end
        mem_step(3, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'h00400013;
        mem_step(3, 1'b0);
        redirect = 1'b0;
        vectors++;
        if (valid !== 1'b0 || instruction !== 32'h0) begin
            miscompares++;
            $display("FAIL rw_flush: got v=%b i=%h want 0/0", valid, instruction);
        end
        for (int i = 0; i < 10 && !imem_req; i++) begin
            mem_step(0, 1'b0);
            vectors++;
            if (valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rw_stale[%0d]: got v=%b pc=%h want v=0", i, valid, pc);
            end
        end
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h00400010) begin
            miscompares++;
            $display("FAIL rw_addr: got req=%b addr=%h want 1/00400010", imem_req, imem_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_step(0, 1'b0);
            if (valid) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen || pc !== 32'h00400010 || instruction !== mem_word(32'h00400010)) begin
            miscompares++;
            $display("FAIL rw_first: got v=%b pc=%h i=%h want 1/00400010/%h", valid, pc, instruction, mem_word(32'h00400010));
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        wait_req(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL sim_idle_timeout: got no request, want request");
        end
        mem_step(1, 1'b0);
        mem_step(0, 1'b0);
        // rvalid fires in this cycle together with the redirect
        redirect    = 1'b1;
        redirect_pc = 32'h00001000;
        mem_step(0, 1'b0);
        redirect = 1'b0;
        vectors++;
        if (valid !== 1'b0 || instruction !== 32'h0) begin
            miscompares++;
            $display("FAIL sim_rv_flush: got v=%b i=%h want 0/0", valid, instruction);
        end
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h00001000) begin
            miscompares++;
            $display("FAIL sim_rv_req: got req=%b addr=%h want 1/00001000", imem_req, imem_addr);
        end
        stall = 1'b1;
        for (int i = 0; i < 6; i++) mem_step(0, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'h00002004;
        cyc();
        redirect = 1'b0;
        vectors++;
        if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00002004) begin
            miscompares++;
            $display("FAIL sim_stall_redir: got v=%b req=%b addr=%h want 0/1/00002004", valid, imem_req, imem_addr);
        end
        stall = 1'b0;
        mem_step(0, 1'b0);
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_flushed: got v=%b pc=%h want v=0", valid, pc);
        end
        mem_step(0, 1'b0);
        vectors++;
        if (valid !== 1'b1 || pc !== 32'h00002004 || instruction !== mem_word(32'h00002004)) begin
            miscompares++;
            $display("FAIL sim_first: got v=%b pc=%h i=%h want 1/00002004/%h", valid, pc, instruction, mem_word(32'h00002004));
        end
    endtask

    task automatic test_wrap();
        bit ok;
        wait_req(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL wrap_idle_timeout: got no request, want request");
        end
        redirect    = 1'b1;
        redirect_pc = 32'hFFFFFFFF;
        cyc();
        redirect = 1'b0;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFFFFFC) begin
            miscompares++;
            $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
        end
        mem_step(0, 1'b0);
        mem_step(0, 1'b0);
        vectors++;
        if (valid !== 1'b1 || pc !== 32'hFFFFFFFC || pc_plus_4 !== 32'h0 || instruction !== mem_word(32'hFFFFFFFC)) begin
            miscompares++;
            $display("FAIL wrap_instr: got v=%b pc=%h pp4=%h i=%h want 1/fffffffc/00000000/%h",
                     valid, pc, pc_plus_4, instruction, mem_word(32'hFFFFFFFC));
        end
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_next: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        wait_req(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rm_idle_timeout: got no request, want request");
        end
        mem_step(3, 1'b0);
        mem_step(3, 1'b0);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (valid !== 1'b0 || instruction !== 32'h0 || pc !== 32'h0 || pc_plus_4 !== 32'h0 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_async: got v=%b i=%h pc=%h pp4=%h req=%b want all 0",
                     valid, instruction, pc, pc_plus_4, imem_req);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL rm_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mem_step(0, 1'b0);
            if (valid) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen || pc !== RESET_PC || instruction !== mem_word(RESET_PC)) begin
            miscompares++;
            $display("FAIL rm_first: got v=%b pc=%h i=%h want 1/%h/%h", valid, pc, instruction, RESET_PC, mem_word(RESET_PC));
        end
    endtask

    // Reference: after a redirect to T, ID must see exactly T, T+4, T+8, ...
    // each carrying mem_word(address), with holds under stall and bubbles
    // reading as nop.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] last_i;
        logic [31:0] last_pc;
        logic [31:0] last_pp4;
        logic        last_v;
        bit          prev_stall;
        bit          prev_redir;
        int          delivered;
        delivered   = 0;
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = $urandom;
        exp_pc      = redirect_pc & 32'hFFFF_FFFC;
        mem_step(3, 1'b1);
        redirect   = 1'b0;
        prev_redir = 1'b1;
        prev_stall = 1'b0;
        last_i = instruction; last_pc = pc; last_pp4 = pc_plus_4; last_v = valid;
        for (int c = 0; c < 3000; c++) begin
            if (prev_redir) begin
                vectors++;
                if (valid !== 1'b0 || instruction !== 32'h0) begin
                    miscompares++;
                    $display("FAIL rnd_redir[%0d]: got v=%b i=%h want 0/0", c, valid, instruction);
                end
            end else if (!prev_stall) begin
                if (valid === 1'b1) begin
                    vectors++;
                    if (pc !== exp_pc || instruction !== mem_word(exp_pc) || pc_plus_4 !== exp_pc + 32'd4) begin
                        miscompares++;
                        $display("FAIL rnd_stream[%0d]: got pc=%h i=%h pp4=%h want %h/%h/%h",
                                 c, pc, instruction, pc_plus_4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                    end
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end else begin
                    vectors++;
                    if (valid !== 1'b0 || instruction !== 32'h0 || pc !== last_pc || pc_plus_4 !== last_pp4) begin
                        miscompares++;
                        $display("FAIL rnd_bubble[%0d]: got v=%b i=%h pc=%h pp4=%h want 0/0/%h/%h",
                                 c, valid, instruction, pc, pc_plus_4, last_pc, last_pp4);
                    end
                end
            end else begin
                vectors++;
                if (valid !== last_v || instruction !== last_i || pc !== last_pc || pc_plus_4 !== last_pp4) begin
                    miscompares++;
                    $display("FAIL rnd_stall[%0d]: got v=%b i=%h pc=%h want %b/%h/%h", c, valid, instruction, pc, last_v, last_i, last_pc);
                end
            end
            vectors++;
            if ((pend && imem_req) || (imem_req && imem_addr[1:0] !== 2'b00)) begin
                miscompares++;
                $display("FAIL rnd_proto[%0d]: got req=%b addr=%h with pending=%b, want no request while pending and aligned address",
                         c, imem_req, imem_addr, pend);
            end
            last_i = instruction; last_pc = pc; last_pp4 = pc_plus_4; last_v = valid;
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 39) == 0);
            if (redirect) begin
                if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
                else                           redirect_pc = $urandom;
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end
            mem_step(3, 1'b1);
            prev_stall = stall;
            prev_redir = redirect;
            redirect   = 1'b0;
        end
        stall = 1'b0;
        vectors++;
        if (delivered < 100) begin
            miscompares++;
            $display("FAIL rnd_progress: got %0d instructions, want at least 100", delivered);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_reset_fetch();
        test_stall_fill();
        test_redirect_wait();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
